gsim: RTL and testbench
=======================

# gsim

Gauss-Seidel iterative solver for a fixed 16×16 symmetric banded system A·x = b. The diagonal of A is 20, off-diagonals ±1 are −13, ±2 are 6 and ±3 are −1; all other entries are 0. The block accepts 16 signed integer b values in a serial burst, then iterates in fixed point. It streams the 16 solution values out as signed Q16.16 words and sits as a standalone accelerator between a producer and a consumer using valid-only strobes.

## Interface
- N_ITER, 16384: number of full Gauss-Seidel sweeps (each sweep updates x0..x15 once).
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; returns the block to IDLE.
- in_en  input  1  qualifies b_in on the current rising edge.
- b_in  input  16  signed two's-complement integer element of b.
- out_valid  output  1  high while x_out carries a valid solution element.
- x_out  output  32  signed Q16.16 solution element.

## Operation
- States are IDLE, LOAD, CALC, OUT.
- **IDLE / LOAD**
  - Every edge with in_en=1 stores b_in into b[k], where k increments 0→15.
  - Edges with in_en=0 hold k; gaps in the burst are allowed.
  - Accepting the 16th value clears x[0..15] to 0 and enters CALC.
- **CALC**
  - One element is updated per cycle, in order i = 0..15, and sweeps repeat.
  - The update uses already-updated neighbours, in Gauss-Seidel order: x_i ← (b_i + 13(x_{i−1}+x_{i+1}) − 6(x_{i−2}+x_{i+2}) + (x_{i−3}+x_{i+3})) / 20.
  - Indices outside 0..15 contribute 0.
- **Arithmetic**
  - b_i is sign-extended and shifted left by 16 into Q16.16.
  - The numerator is formed in 40-bit signed.
  - Division by 20 is multiply by 52429, then arithmetic shift right 20.
  - The result saturates to the 32-bit signed range.
- After N_ITER complete sweeps, go to OUT.
- **OUT**: x[0]..x[15] are presented on 16 consecutive cycles with out_valid=1. The block then returns to IDLE, ready for a new burst.
- in_en is ignored during CALC and OUT.

## Timing
- Reset values: out_valid=0, x_out=0, state IDLE, k=0, all x and b registers 0.
- Load: 16 accepted edges; CALC starts on the cycle after the 16th accept.
- Compute latency is 16·N_ITER cycles.
- Output: out_valid is registered and rises on the edge that ends CALC. x_out changes only at rising edges, so it is stable for the full cycle, sampleable at negedge.
- Between bursts: out_valid=0 and x_out holds 0.
- Reset asserted in any state aborts immediately. Outputs go to reset values, and a partial burst or partial output stream is discarded.

## Configuration
- GSIM_ROUND_EN defined: before the >>20 shift, add 2^19 (round half up toward +∞).
- GSIM_ROUND_EN undefined: plain arithmetic shift (truncation toward −∞).
- Interface and timing are identical in both builds.

## Test plan
- Reset check: assert reset=0 mid-run, then release → out_valid=0 and x_out=0 immediately; the block accepts a fresh 16-word burst afterwards.
- All-zero b burst → after 16·N_ITER cycles, 16 out_valid pulses with x_out=0x00000000.
- **Contiguous burst, golden solution**
  - Drive a 16-word burst whose exact solution is x = (3357.0527, 3331.6573, −358.9862, −732.4078, 1445.8347, 3809.3571, 3275.8464, −2304.1421, −5725.0258, −3237.6062, 3156.1618, 4247.9033, 1984.8291, 1028.3355, 1055.5862, 959.5718).
  - Decoded outputs must match.
  - Σ(A·x − b)² must be < 0.3, with < 1e-3 as the target.
- Gapped burst: same data with in_en dropped for 3 cycles between words 7 and 8 → identical output values, with the start delayed by 3 cycles.
- in_en=1 with random b_in during CALC and OUT → results unchanged, and exactly 16 valid outputs.
- b0=20, others 0, with N_ITER=1 → x_out[0]=0x00010000 (1.0); later elements follow the first-sweep recurrence exactly, bit-true to the specified arithmetic.

Source files
------------

// File: rtl/gsim.sv
// gsim: Gauss-Seidel solver for the fixed 16x16 banded system A.x = b.
// Band of A: diagonal 20, +/-1 -> -13, +/-2 -> 6, +/-3 -> -1.
// The b burst is loaded serially, N_ITER sweeps run one element per cycle,
// then x[0..15] streams out as signed Q16.16.
// Build option: define GSIM_ROUND_EN to round the divide-by-20 half up
// instead of truncating toward -inf.
module gsim #(
    parameter int N_ITER = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_en,
    input  logic [15:0] b_in,
    output logic        out_valid,
    output logic [31:0] x_out
);

    // state | meaning
    // IDLE  | waiting for the first word of a burst
    // LOAD  | collecting the remaining b words
    // CALC  | one Gauss-Seidel element update per cycle
    // OUT   | streaming x[1..15] (x[0] leaves on the CALC exit edge)
    typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

    localparam int IW = (N_ITER > 1) ? $clog2(N_ITER) : 1;

    state_t state, state_nxt;

    logic [3:0]          k_cnt;
    logic [3:0]          idx;
    logic [IW-1:0]       iter_cnt;
    logic signed [15:0]  b_reg [16];
    logic signed [31:0]  x_reg [16];

    logic accept, load_last, sweep_end, calc_done, out_done;

    logic signed [39:0] nbr [7];
    logic signed [31:0] x_tap;
    logic signed [15:0] b_cur;
    logic signed [39:0] num;
    logic signed [63:0] prod;
    logic signed [63:0] quo;
    logic [31:0]        x_new;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and the qualifying strobes used by the datapath.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load_last = 1'b0;
        sweep_end = 1'b0;
        calc_done = 1'b0;
        out_done  = 1'b0;
        case (state)
            IDLE: begin
                accept = in_en;
                if (accept) state_nxt = LOAD;
            end
            LOAD: begin
                accept    = in_en;
                load_last = in_en && (k_cnt == 4'd15);
                if (load_last) state_nxt = CALC;
            end
            CALC: begin
                sweep_end = (idx == 4'd15);
                calc_done = sweep_end && (iter_cnt == '0);
                if (calc_done) state_nxt = OUT;
            end
            OUT: begin
                out_done = (idx == 4'd0);
                if (out_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Element update: gather the +/-3 neighbourhood (zero outside 0..15),
    // form the 40-bit numerator, divide by 20 via *52429 >> 20, saturate.
    always_comb begin
        x_tap = '0;
        for (int d = 0; d < 7; d++) begin
            nbr[d] = '0;
            if ((int'(idx) + d >= 3) && (int'(idx) + d <= 18)) begin
                x_tap  = x_reg[idx + 4'(d) - 4'd3];
                nbr[d] = {{8{x_tap[31]}}, x_tap};
            end
        end
        b_cur = b_reg[idx];
        num   = $signed({{8{b_cur[15]}}, b_cur, 16'h0000})
              + 40'sd13 * (nbr[2] + nbr[4])
              - 40'sd6  * (nbr[1] + nbr[5])
              + (nbr[0] + nbr[6]);
        prod  = $signed({{24{num[39]}}, num}) * 64'sd52429;
`ifdef GSIM_ROUND_EN
        quo   = (prod + 64'sd524288) >>> 20;
`else
        quo   = prod >>> 20;
`endif
        if (quo > 64'sd2147483647)
            x_new = 32'h7FFF_FFFF;
        else if (quo < -64'sd2147483648)
            x_new = 32'h8000_0000;
        else
            x_new = quo[31:0];
    end

    // Load counter, b/x storage, sweep counter and registered output stream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_cnt     <= '0;
            idx       <= '0;
            iter_cnt  <= '0;
            out_valid <= 1'b0;
            x_out     <= '0;
            for (int i = 0; i < 16; i++) begin
                b_reg[i] <= '0;
                x_reg[i] <= '0;
            end
        end else begin
            if (accept) begin
                b_reg[k_cnt] <= b_in;
                k_cnt        <= k_cnt + 4'd1;
            end
            if (load_last) begin
                for (int i = 0; i < 16; i++) x_reg[i] <= '0;
                idx      <= '0;
                iter_cnt <= IW'(N_ITER - 1);
            end
            if (state == CALC) begin
                x_reg[idx] <= x_new;
                idx        <= idx + 4'd1;
                if (calc_done) begin
                    out_valid <= 1'b1;
                    x_out     <= x_reg[0];
                    idx       <= 4'd1;
                end else if (sweep_end) begin
                    iter_cnt <= iter_cnt - 1'b1;
                end
            end
            if (state == OUT) begin
                if (out_done) begin
                    out_valid <= 1'b0;
                    x_out     <= '0;
                end else begin
                    x_out <= x_reg[idx];
                    idx   <= idx + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gsim.sv
// Bench for gsim: two instances (3 sweeps and 1 sweep) share the inputs;
// expected solutions come from a matrix-level Gauss-Seidel model.
module tb_gsim;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_en = 1'b0;
    logic [15:0] b_in = '0;
    logic        ov3, ov1;
    logic [31:0] x3, x1;

    gsim #(.N_ITER(3)) dut3 (.clk(clk), .reset(rst), .in_en(in_en), .b_in(b_in),
                             .out_valid(ov3), .x_out(x3));
    gsim #(.N_ITER(1)) dut1 (.clk(clk), .reset(rst), .in_en(in_en), .b_in(b_in),
                             .out_valid(ov1), .x_out(x1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic signed [15:0] cur_b [16];
    logic [31:0]        exp_x [2][16];
    int                 niter_of [2] = '{3, 1};

    logic [31:0] cap_x   [2][16];
    logic        cap_ov  [2][16];
    int          cap_start [2];
    bit          cap_got [2];
    logic        cap_tail_ov [2];
    logic [31:0] cap_tail_x  [2];

    function automatic logic get_ov(input int sel);
        return (sel == 0) ? ov3 : ov1;
    endfunction

    function automatic logic [31:0] get_x(input int sel);
        return (sel == 0) ? x3 : x1;
    endfunction

    function automatic longint a_coef(input int i, input int j);
        int d;
        d = (i > j) ? i - j : j - i;
        case (d)
            0: return 20;
            1: return -13;
            2: return 6;
            3: return -1;
            default: return 0;
        endcase
    endfunction

    // Gauss-Seidel on the full matrix with the block's fixed-point divide.
    function automatic void run_model(input int sel);
        longint xs [16];
        longint acc, q;
        for (int i = 0; i < 16; i++) xs[i] = 0;
        for (int s = 0; s < niter_of[sel]; s++) begin
            for (int i = 0; i < 16; i++) begin
                acc = longint'(cur_b[i]) * 65536;
                for (int j = 0; j < 16; j++)
                    if (j != i) acc = acc - a_coef(i, j) * xs[j];
                acc = acc * 52429;
`ifdef GSIM_ROUND_EN
                acc = acc + 524288;
`endif
                q = acc >>> 20;
                if (q > 64'sd2147483647)       q = 64'sd2147483647;
                else if (q < -64'sd2147483648) q = -64'sd2147483648;
                xs[i] = q;
            end
        end
        for (int i = 0; i < 16; i++) exp_x[sel][i] = xs[i][31:0];
    endfunction

    // Drives cur_b as a burst; optional idle gap after word 7. Ends on a negedge.
    task automatic drive_burst(input int gap, output int c0);
        @(negedge clk);
        c0 = cyc;
        for (int k = 0; k < 16; k++) begin
            in_en = 1'b1;
            b_in  = cur_b[k];
            @(negedge clk);
            if (k == 7) begin
                repeat (gap) begin
                    in_en = 1'b0;
                    b_in  = 16'($urandom);
                    @(negedge clk);
                end
            end
        end
        in_en = 1'b0;
        b_in  = '0;
    endtask

    // Records one 16-word output stream plus the following cycle (no judging).
    task automatic capture(input int sel);
        int waited;
        waited = 0;
        cap_got[sel] = 1'b0;
        while (get_ov(sel) !== 1'b1 && waited < 4000) begin
            @(negedge clk);
            waited++;
        end
        if (get_ov(sel) !== 1'b1) return;
        cap_got[sel]   = 1'b1;
        cap_start[sel] = cyc;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            cap_ov[sel][i] = get_ov(sel);
            cap_x[sel][i]  = get_x(sel);
        end
        @(negedge clk);
        cap_tail_ov[sel] = get_ov(sel);
        cap_tail_x[sel]  = get_x(sel);
    endtask

    task automatic random_b();
        for (int k = 0; k < 16; k++) cur_b[k] = 16'($urandom);
    endtask

    task automatic test_reset();
        int c0;
        int seen;
        repeat (3) @(negedge clk);
        checks++;
        if (ov3 !== 1'b0 || x3 !== 32'h0 || ov1 !== 1'b0 || x1 !== 32'h0) begin
            failures++;
            $display("FAIL reset_init: ov3=%b x3=%h ov1=%b x1=%h, want 0/0", ov3, x3, ov1, x1);
        end
        rst = 1'b1;
        // partial burst, then abort
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); in_en = 1'b1; b_in = 16'($urandom);
        end
        @(negedge clk); in_en = 1'b0; rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        random_b();
        drive_burst(0, c0);
        run_model(0); run_model(1);
        capture(1);
        checks++;
        if (!cap_got[1] || cap_start[1] !== c0 + 16 + 16) begin
            failures++;
            $display("FAIL reset_partial_start: got=%0d at=%0d want=%0d", cap_got[1], cap_start[1], c0 + 32);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (cap_ov[1][i] !== 1'b1 || cap_x[1][i] !== exp_x[1][i]) begin
                failures++;
                $display("FAIL reset_partial_x%0d: ov=%b x=%h want 1/%h", i, cap_ov[1][i], cap_x[1][i], exp_x[1][i]);
            end
        end
        // dut1 now back in IDLE, dut3 still in CALC; abort everything mid-run
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ov3 !== 1'b0 || x3 !== 32'h0 || ov1 !== 1'b0 || x1 !== 32'h0) begin
            failures++;
            $display("FAIL reset_async: ov3=%b x3=%h ov1=%b x1=%h, want 0/0", ov3, x3, ov1, x1);
        end
        @(negedge clk); rst = 1'b1;
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (ov3 !== 1'b0 || x3 !== 32'h0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_discard: %0d active output cycles after abort, want 0", seen);
        end
    endtask

    // Full check of both instances after one burst.
    task automatic test_burst(input string tag, input int gap);
        int c0;
        int want;
        drive_burst(gap, c0);
        run_model(0); run_model(1);
        capture(1);
        capture(0);
        for (int s = 0; s < 2; s++) begin
            want = c0 + 16 + gap + 16 * niter_of[s];
            checks++;
            if (!cap_got[s] || cap_start[s] !== want) begin
                failures++;
                $display("FAIL %s_start dut%0d: got=%0d at=%0d want=%0d", tag, s, cap_got[s], cap_start[s], want);
            end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (cap_ov[s][i] !== 1'b1 || cap_x[s][i] !== exp_x[s][i]) begin
                    failures++;
                    $display("FAIL %s_x%0d dut%0d: ov=%b x=%h want 1/%h", tag, i, s, cap_ov[s][i], cap_x[s][i], exp_x[s][i]);
                end
            end
            checks++;
            if (cap_tail_ov[s] !== 1'b0 || cap_tail_x[s] !== 32'h0) begin
                failures++;
                $display("FAIL %s_tail dut%0d: ov=%b x=%h want 0/0", tag, s, cap_tail_ov[s], cap_tail_x[s]);
            end
        end
    endtask

    task automatic test_zero();
        for (int k = 0; k < 16; k++) cur_b[k] = '0;
        test_burst("zero", 0);
    endtask

    task automatic test_random();
        random_b();
        test_burst("rand", 0);
        for (int k = 0; k < 16; k++) cur_b[k] = (k % 2 == 0) ? 16'sh7FFF : 16'sh8000;
        test_burst("extreme", 0);
    endtask

    task automatic test_gapped();
        random_b();
        test_burst("contig", 0);
        test_burst("gapped", 3);
    endtask

    task automatic test_unit();
        for (int k = 0; k < 16; k++) cur_b[k] = '0;
        cur_b[0] = 16'sd20;
        test_burst("unit", 0);
        checks++;
        if (cap_x[1][0] !== 32'h0001_0000) begin
            failures++;
            $display("FAIL unit_x0_const: x=%h want 00010000", cap_x[1][0]);
        end
    endtask

    task automatic test_ignore_in_en();
        int  c0;
        bit  stop;
        random_b();
        drive_burst(0, c0);
        run_model(0); run_model(1);
        stop = 1'b0;
        fork
            begin
                capture(1);
                capture(0);
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    in_en = 1'b1;
                    b_in  = 16'($urandom);
                    @(negedge clk);
                end
                in_en = 1'b0;
            end
        join
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (!cap_got[s] || cap_start[s] !== c0 + 16 + 16 * niter_of[s]) begin
                failures++;
                $display("FAIL noise_start dut%0d: got=%0d at=%0d want=%0d", s, cap_got[s], cap_start[s], c0 + 16 + 16 * niter_of[s]);
            end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (cap_ov[s][i] !== 1'b1 || cap_x[s][i] !== exp_x[s][i]) begin
                    failures++;
                    $display("FAIL noise_x%0d dut%0d: ov=%b x=%h want 1/%h", i, s, cap_ov[s][i], cap_x[s][i], exp_x[s][i]);
                end
            end
        end
        checks++;
        if (cap_tail_ov[0] !== 1'b0) begin
            failures++;
            $display("FAIL noise_count: out_valid=%b after 16 words, want 0", cap_tail_ov[0]);
        end
        // dut1 has swallowed noise words while idle; clear both
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_back_to_back();
        random_b();
        test_burst("b2b_a", 0);
        random_b();
        test_burst("b2b_b", 0);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_random();
        test_gapped();
        test_unit();
        test_ignore_in_en();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
